audio_mixer_nch: RTL and testbench

- Parametrised N-channel stereo audio mixer with a 1-bit sigma-delta output per side; next generation of the fixed-source mixer.
- Sits between the sound sources (SAA1099 L/R, beeper, mic, ear, future sources) and the board's audio_out_left/right pins.
- Adds per-channel volume, per-channel L/R routing, saturation, and a registered PCM tap (sample_l/sample_r) for other consumers.
- Time-multiplexes one multiplier/adder across channels in a frame FSM.

---
 rtl/audio_pkg.sv | 18 +
 rtl/sigma_delta_dac.sv | 22 ++
 rtl/audio_mixer_nch.sv | 130 +++++++++++++
 tb/tb_audio_mixer_nch.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared width helpers and frame FSM encoding for the N-channel mixer.
package audio_pkg;

   typedef enum logic [1:0] {SNAP, ACC, LATCH} state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Headroom of clog2(nch)+1 bits keeps the per-side sum from ever wrapping.
   function automatic int acc_width(input int w, input int volw, input int nch);
      return w + volw + clog2(nch) + 1;
   endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order 1-bit sigma-delta modulator; output density equals din/2^OUTW.
module sigma_delta_dac #(
   parameter int OUTW = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OUTW-1:0] din,
   output logic            dout
);

   logic [OUTW:0] acc_q, acc_d;

   always_comb acc_d = {1'b0, acc_q[OUTW-1:0]} + {1'b0, din};

   always_ff @(posedge clk) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign dout = acc_q[OUTW];

endmodule

// File: rtl/audio_mixer_nch.sv
// audio_mixer_nch: N-channel stereo mixer sharing one multiply-accumulate across channels,
// with per-channel volume and routing, saturating PCM tap and per-side PDM outputs.
module audio_mixer_nch
   import audio_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int W     = 8,
   parameter int VOLW  = 4,
   parameter int OUTW  = 12,
   parameter int SHIFT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*W-1:0]     ch_data,
   input  logic [NCH*VOLW-1:0]  ch_vol,
   input  logic [2*NCH-1:0]     ch_pan,
   output logic [OUTW-1:0]      sample_l,
   output logic [OUTW-1:0]      sample_r,
   output logic                 sample_valid,
   output logic                 audio_left,
   output logic                 audio_right
);

   localparam int ACCW = acc_width(W, VOLW, NCH);
   localparam int IDXW = (clog2(NCH) > 0) ? clog2(NCH) : 1;
   localparam int PW   = W + VOLW;
   localparam int CW   = ((ACCW > OUTW) ? ACCW : OUTW) + 1;
   localparam logic [OUTW-1:0] FULL = '1;

   state_e                state_q, state_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [ACCW-1:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [NCH*W-1:0]      snap_data_q, snap_data_d;
   logic [NCH*VOLW-1:0]   snap_vol_q, snap_vol_d;
   logic [2*NCH-1:0]      snap_pan_q, snap_pan_d;
   logic [OUTW-1:0]       sample_l_q, sample_l_d, sample_r_q, sample_r_d;
   logic                  valid_q, valid_d;
   logic [PW-1:0]         prod;
   logic [1:0]            pan;
   logic [CW-1:0]         sum_l, sum_r;
   logic                  last;

   assign prod  = PW'(snap_data_q[idx_q*W +: W]) * PW'(snap_vol_q[idx_q*VOLW +: VOLW]);
   assign pan   = snap_pan_q[2*idx_q +: 2];
   assign last  = idx_q == IDXW'(NCH - 1);
   assign sum_l = CW'(acc_l_q >> SHIFT);
   assign sum_r = CW'(acc_r_q >> SHIFT);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_l_d     = acc_l_q;
      acc_r_d     = acc_r_q;
      snap_data_d = snap_data_q;
      snap_vol_d  = snap_vol_q;
      snap_pan_d  = snap_pan_q;
      sample_l_d  = sample_l_q;
      sample_r_d  = sample_r_q;
      valid_d     = 1'b0;
      case (state_q)
         SNAP: begin
            snap_data_d = ch_data;
            snap_vol_d  = ch_vol;
            snap_pan_d  = ch_pan;
            acc_l_d     = '0;
            acc_r_d     = '0;
            idx_d       = '0;
            state_d     = ACC;
         end
         ACC: begin
            acc_l_d = acc_l_q + (pan[0] ? ACCW'(prod) : '0);
            acc_r_d = acc_r_q + (pan[1] ? ACCW'(prod) : '0);
            idx_d   = idx_q + 1'b1;
            state_d = last ? LATCH : ACC;
         end
         LATCH: begin
            sample_l_d = (sum_l > CW'(FULL)) ? FULL : sum_l[OUTW-1:0];
            sample_r_d = (sum_r > CW'(FULL)) ? FULL : sum_r[OUTW-1:0];
            valid_d    = 1'b1;
            state_d    = SNAP;
         end
         default: state_d = SNAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= SNAP;
         idx_q       <= '0;
         acc_l_q     <= '0;
         acc_r_q     <= '0;
         snap_data_q <= '0;
         snap_vol_q  <= '0;
         snap_pan_q  <= '0;
         sample_l_q  <= '0;
         sample_r_q  <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_l_q     <= acc_l_d;
         acc_r_q     <= acc_r_d;
         snap_data_q <= snap_data_d;
         snap_vol_q  <= snap_vol_d;
         snap_pan_q  <= snap_pan_d;
         sample_l_q  <= sample_l_d;
         sample_r_q  <= sample_r_d;
         valid_q     <= valid_d;
      end
   end

   assign sample_l     = sample_l_q;
   assign sample_r     = sample_r_q;
   assign sample_valid = valid_q;

   sigma_delta_dac #(.OUTW(OUTW)) u_dac_l (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sample_l_q),
      .dout  (audio_left)
   );

   sigma_delta_dac #(.OUTW(OUTW)) u_dac_r (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sample_r_q),
      .dout  (audio_right)
   );

endmodule

// File: tb/tb_audio_mixer_nch.sv
// tb_audio_mixer_nch: scoreboard bench; a frame model is queued at every SNAP edge and
// checked against sample_l/sample_r when sample_valid pulses.
module tb_audio_mixer_nch;

   localparam int NCH   = 4;
   localparam int W     = 8;
   localparam int VOLW  = 4;
   localparam int OUTW  = 12;
   localparam int SHIFT = 1;
   localparam int FRAME = NCH + 2;
   localparam int MAXS  = (1 << OUTW) - 1;

   typedef struct {int l; int r; int e;} exp_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NCH*W-1:0]    ch_data = '0;
   logic [NCH*VOLW-1:0] ch_vol = '0;
   logic [2*NCH-1:0]    ch_pan = '0;
   logic [OUTW-1:0]     sample_l, sample_r;
   logic                sample_valid, audio_left, audio_right;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   audio_mixer_nch #(.NCH(NCH), .W(W), .VOLW(VOLW), .OUTW(OUTW), .SHIFT(SHIFT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_data      (ch_data),
      .ch_vol       (ch_vol),
      .ch_pan       (ch_pan),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .audio_left   (audio_left),
      .audio_right  (audio_right)
   );

   function automatic exp_t model(input logic [NCH*W-1:0] d, input logic [NCH*VOLW-1:0] v,
                                  input logic [2*NCH-1:0] p, input int e);
      exp_t x;
      int   prod;
      x.l = 0;
      x.r = 0;
      x.e = e;
      for (int i = 0; i < NCH; i++) begin
         prod = int'(d[i*W +: W]) * int'(v[i*VOLW +: VOLW]);
         if (p[2*i])   x.l += prod;
         if (p[2*i+1]) x.r += prod;
      end
      x.l = x.l >> SHIFT;
      x.r = x.r >> SHIFT;
      if (x.l > MAXS) x.l = MAXS;
      if (x.r > MAXS) x.r = MAXS;
      return x;
   endfunction

   // cyc counts clock edges since reset release; edges 1, 1+FRAME, ... are SNAP edges.
   always @(posedge clk) begin
      if (!rst_n) begin
         cyc <= 0;
         sbq.delete();
      end else begin
         if (cyc % FRAME == 0) sbq.push_back(model(ch_data, ch_vol, ch_pan, cyc + 1 + NCH + 1));
         cyc <= cyc + 1;
      end
   end

   task automatic get_frame(output bit ok, output exp_t x);
      ok = 1'b0;
      x  = '{0, 0, -1};
      for (int i = 0; i < 3*FRAME; i++) begin
         @(posedge clk); #1;
         if (sample_valid) begin
            ok = 1'b1;
            break;
         end
      end
      while (sbq.size() > 0 && sbq[0].e < cyc) void'(sbq.pop_front());
      if (ok && sbq.size() > 0) x = sbq.pop_front();
      else ok = 1'b0;
   endtask

   task automatic test_reset();
      bit   ok;
      bit   noisy;
      exp_t x;
      rst_n = 1'b0;
      ch_data = '0; ch_vol = '0; ch_pan = '0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({sample_l, sample_r, sample_valid, audio_left, audio_right} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got l=%0d r=%0d v=%0b al=%0b ar=%0b, expected all 0",
                  sample_l, sample_r, sample_valid, audio_left, audio_right);
      end
      rst_n = 1'b1;
      get_frame(ok, x);
      n_chk++;
      if (!ok || cyc !== FRAME) begin
         n_fail++;
         $display("FAIL first_valid: got ok=%0b cycle=%0d, expected cycle=%0d", ok, cyc, FRAME);
      end
      n_chk++;
      if (sample_l !== 0 || sample_r !== 0) begin
         n_fail++;
         $display("FAIL reset_sample: got l=%0d r=%0d, expected 0 0", sample_l, sample_r);
      end
      noisy = 1'b0;
      repeat (2*FRAME) begin
         @(posedge clk); #1;
         noisy |= audio_left | audio_right;
      end
      n_chk++;
      if (noisy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_audio: got activity=%0b, expected 0", noisy);
      end
   endtask

   task automatic test_single_left();
      bit   ok;
      exp_t x;
      ch_data = 32'h0000_0080; ch_vol = 16'h000F; ch_pan = 8'b0000_0001;
      for (int f = 0; f < 3; f++) begin
         get_frame(ok, x);
         n_chk++;
         if (!ok || cyc !== x.e || sample_l !== x.l || sample_r !== x.r) begin
            n_fail++;
            $display("FAIL single_left_frame%0d: got ok=%0b cyc=%0d l=%0d r=%0d, expected cyc=%0d l=%0d r=%0d",
                     f, ok, cyc, sample_l, sample_r, x.e, x.l, x.r);
         end
      end
      n_chk++;
      if (sample_l !== 960 || sample_r !== 0) begin
         n_fail++;
         $display("FAIL single_left_value: got l=%0d r=%0d, expected 960 0", sample_l, sample_r);
      end
   endtask

   task automatic test_saturate();
      bit   ok;
      exp_t x;
      int   ones_l, ones_r;
      ch_data = '1; ch_vol = '1; ch_pan = '1;
      for (int f = 0; f < 3; f++) begin
         get_frame(ok, x);
         n_chk++;
         if (!ok || cyc !== x.e || sample_l !== x.l || sample_r !== x.r) begin
            n_fail++;
            $display("FAIL saturate_frame%0d: got ok=%0b cyc=%0d l=%0d r=%0d, expected cyc=%0d l=%0d r=%0d",
                     f, ok, cyc, sample_l, sample_r, x.e, x.l, x.r);
         end
      end
      n_chk++;
      if (sample_l !== MAXS || sample_r !== MAXS) begin
         n_fail++;
         $display("FAIL saturate_value: got l=%0d r=%0d, expected %0d %0d", sample_l, sample_r, MAXS, MAXS);
      end
      ones_l = 0; ones_r = 0;
      repeat (1 << OUTW) begin
         @(posedge clk); #1;
         ones_l += int'(audio_left);
         ones_r += int'(audio_right);
      end
      n_chk++;
      if (ones_l != MAXS || ones_r != MAXS) begin
         n_fail++;
         $display("FAIL saturate_density: got left=%0d right=%0d ones, expected %0d", ones_l, ones_r, MAXS);
      end
   endtask

   task automatic test_right_density();
      bit   ok;
      exp_t x;
      int   ones_l, ones_r;
      ch_data = 32'h0000_4000; ch_vol = 16'h0080; ch_pan = 8'b0000_1000;
      for (int f = 0; f < 2; f++) begin
         get_frame(ok, x);
         n_chk++;
         if (!ok || cyc !== x.e || sample_l !== x.l || sample_r !== x.r) begin
            n_fail++;
            $display("FAIL right_frame%0d: got ok=%0b cyc=%0d l=%0d r=%0d, expected cyc=%0d l=%0d r=%0d",
                     f, ok, cyc, sample_l, sample_r, x.e, x.l, x.r);
         end
      end
      n_chk++;
      if (sample_l !== 0 || sample_r !== 256) begin
         n_fail++;
         $display("FAIL right_value: got l=%0d r=%0d, expected 0 256", sample_l, sample_r);
      end
      ones_l = 0; ones_r = 0;
      repeat (1 << OUTW) begin
         @(posedge clk); #1;
         ones_l += int'(audio_left);
         ones_r += int'(audio_right);
      end
      n_chk++;
      if (ones_r != 256 || ones_l != 0) begin
         n_fail++;
         $display("FAIL right_density: got left=%0d right=%0d ones, expected 0 256", ones_l, ones_r);
      end
   endtask

   task automatic test_half_scale();
      bit   ok;
      exp_t x;
      logic want;
      rst_n = 1'b0;
      ch_data = 32'h0080_8080; ch_vol = 16'h02FF; ch_pan = 8'b0001_0101;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      get_frame(ok, x);
      n_chk++;
      if (!ok || cyc !== FRAME || sample_l !== 2048 || sample_l !== x.l || sample_r !== 0) begin
         n_fail++;
         $display("FAIL half_value: got ok=%0b cyc=%0d l=%0d r=%0d, expected cyc=%0d l=2048 r=0",
                  ok, cyc, sample_l, sample_r, FRAME);
      end
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         want = (k % 2 == 0);
         n_chk++;
         if (audio_left !== want || audio_right !== 1'b0) begin
            n_fail++;
            $display("FAIL half_pdm_cycle%0d: got al=%0b ar=%0b, expected al=%0b ar=0", k, audio_left, audio_right, want);
         end
      end
   endtask

   task automatic test_snapshot();
      bit   ok;
      exp_t x;
      ch_data = 32'h0000_0010; ch_vol = 16'h000F; ch_pan = 8'b0000_0001;
      get_frame(ok, x);
      get_frame(ok, x);
      @(posedge clk); #1;
      @(posedge clk); #1;
      ch_data = 32'h0000_0020;
      get_frame(ok, x);
      n_chk++;
      if (!ok || cyc !== x.e || sample_l !== x.l || sample_l !== 120) begin
         n_fail++;
         $display("FAIL snapshot_current: got ok=%0b l=%0d, expected l=120 (model %0d)", ok, sample_l, x.l);
      end
      get_frame(ok, x);
      n_chk++;
      if (!ok || cyc !== x.e || sample_l !== x.l || sample_l !== 240) begin
         n_fail++;
         $display("FAIL snapshot_next: got ok=%0b l=%0d, expected l=240 (model %0d)", ok, sample_l, x.l);
      end
   endtask

   task automatic test_mid_reset();
      bit   ok;
      bit   seen;
      exp_t x;
      get_frame(ok, x);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      seen = 1'b0;
      repeat (2*FRAME) begin
         @(posedge clk); #1;
         seen |= sample_valid;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_valid: got pulse=%0b, expected 0", seen);
      end
      n_chk++;
      if (sample_l !== 0 || sample_r !== 0 || audio_left !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_clear: got l=%0d r=%0d al=%0b, expected 0 0 0", sample_l, sample_r, audio_left);
      end
      rst_n = 1'b1;
      get_frame(ok, x);
      n_chk++;
      if (!ok || cyc !== FRAME || sample_l !== 240 || sample_l !== x.l) begin
         n_fail++;
         $display("FAIL midreset_recover: got ok=%0b cyc=%0d l=%0d, expected cyc=%0d l=240", ok, cyc, sample_l, FRAME);
      end
   endtask

   initial begin
      test_reset();
      test_single_left();
      test_saturate();
      test_right_density();
      test_half_scale();
      test_snapshot();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
